// File: rtl/lcd_pattern_gen.sv
// LCD timing and test-pattern generator.
// Owns the horizontal/vertical counters and produces registered HSYNC/VSYNC/DEN,
// pixel coordinates and 5-6-5 style RGB for one of four test patterns.
// Every output is computed from counter state (h,v) and appears one cycle later,
// so syncs, DEN, coordinates and colour stay mutually aligned.
module lcd_pattern_gen #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 210,
    parameter int H_SYNC      = 1,
    parameter int H_BP        = 182,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 22,
    parameter int V_SYNC      = 1,
    parameter int V_BP        = 23,
    parameter int R_BITS      = 5,
    parameter int G_BITS      = 6,
    parameter int B_BITS      = 5,
    parameter int CHECK_SHIFT = 5,
    parameter int SCROLL_DX   = 3,
    parameter int SCROLL_DY   = 2
) (
    input  logic              PIXEL_CLK,
    input  logic              RESET,
    input  logic              MODE_NEXT,
    input  logic              SCROLL_EN,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic              DEN,
    output logic [R_BITS-1:0] LCD_R,
    output logic [G_BITS-1:0] LCD_G,
    output logic [B_BITS-1:0] LCD_B,
    output logic [10:0]       XPOS,
    output logic [10:0]       YPOS,
    output logic [1:0]        MODE,
    output logic              FRAME_START
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // A panel narrower than 8 pixels still gets 1-pixel bars rather than zero-width ones.
    localparam int BAR_W_RAW = H_ACTIVE / 8;
    localparam int BAR_W     = (BAR_W_RAW < 1) ? 1 : BAR_W_RAW;

    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);
    localparam logic [7:0]  STEP_X   = 8'(SCROLL_DX);
    localparam logic [7:0]  STEP_Y   = 8'(SCROLL_DY);

    typedef enum logic [1:0] {
        MODE_CHECKER = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_RAMP    = 2'd2,
        MODE_WHITE   = 2'd3
    } mode_t;

    logic [10:0] h_q, h_d, v_q, v_d;
    logic [10:0] bar_px_q, bar_px_d;
    logic [3:0]  bar_idx_q, bar_idx_d;
    logic        pending_q, pending_d;
    mode_t       mode_q, mode_d;
    logic [7:0]  offx_q, offx_d, offy_q, offy_d;

    logic              hsync_q, vsync_q, den_q, fs_q;
    logic [R_BITS-1:0] r_q, r_d;
    logic [G_BITS-1:0] g_q, g_d;
    logic [B_BITS-1:0] b_q, b_d;
    logic [10:0]       x_q, y_q;

    logic at_origin;
    logic h_active, v_active, h_sync, v_sync;
    logic [2:0] ox_bits, oy_bits;
    logic [2:0] bar_sel;
    logic       bar_on;

    assign at_origin = (h_q == 11'd0) && (v_q == 11'd0);
    assign h_active  = h_q < H_ACT;
    assign v_active  = v_q < V_ACT;
    assign h_sync    = (h_q >= HS_START) && (h_q < HS_END);
    assign v_sync    = (v_q >= VS_START) && (v_q < VS_END);

    // Raster counters: h wraps each line, v advances on h wrap and wraps each frame.
    always_comb begin
        h_d = h_q + 11'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = 11'd0;
            v_d = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
        end
    end

    // Bar position tracked incrementally so no divider is needed; index 8 means past the last bar.
    always_comb begin
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;
        if (h_q == H_LAST) begin
            bar_px_d  = 11'd0;
            bar_idx_d = 4'd0;
        end else if (h_active) begin
            if (bar_px_q == BAR_LAST) begin
                bar_px_d = 11'd0;
                if (bar_idx_q != 4'd8) begin
                    bar_idx_d = bar_idx_q + 4'd1;
                end
            end else begin
                bar_px_d = bar_px_q + 11'd1;
            end
        end
    end

    // Frame-boundary controls: the mode request and scroll step are folded in at (0,0)
    // so the frame that starts at this pixel already uses the new values.
    always_comb begin
        mode_d    = mode_q;
        offx_d    = offx_q;
        offy_d    = offy_q;
        pending_d = pending_q | MODE_NEXT;
        if (at_origin) begin
            pending_d = 1'b0;
            if (pending_q || MODE_NEXT) begin
                mode_d = mode_t'(mode_q + 2'd1);
            end
            if (SCROLL_EN) begin
                offx_d = offx_q + STEP_X;
                offy_d = offy_q + STEP_Y;
            end
        end
    end

    assign ox_bits = 3'((h_q + {3'b000, offx_d}) >> CHECK_SHIFT);
    assign oy_bits = 3'((v_q + {3'b000, offy_d}) >> CHECK_SHIFT);
    assign bar_on  = bar_idx_q < 4'd8;
    assign bar_sel = bar_idx_q[2:0];

    // Pixel colour for the current counter position; forced to black outside the visible area.
    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        case (mode_d)
            MODE_CHECKER: begin
                r_d = {R_BITS{ox_bits[0] ^ oy_bits[0]}};
                g_d = {G_BITS{ox_bits[1] ^ oy_bits[1]}};
                b_d = {B_BITS{ox_bits[2] ^ oy_bits[2]}};
            end
            MODE_BARS: begin
                r_d = {R_BITS{bar_on & ~bar_sel[1]}};
                g_d = {G_BITS{bar_on & ~bar_sel[2]}};
                b_d = {B_BITS{bar_on & ~bar_sel[0]}};
            end
            MODE_RAMP: begin
                r_d = h_q[7 -: R_BITS];
                g_d = h_q[7 -: G_BITS];
                b_d = h_q[7 -: B_BITS];
            end
            default: begin
                r_d = '1;
                g_d = '1;
                b_d = '1;
            end
        endcase
        if (!(h_active && v_active)) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    // State registers: counters, bar tracker, mode and scroll offsets.
    always_ff @(posedge PIXEL_CLK or posedge RESET) begin
        if (RESET) begin
            h_q       <= 11'd0;
            v_q       <= 11'd0;
            bar_px_q  <= 11'd0;
            bar_idx_q <= 4'd0;
            pending_q <= 1'b0;
            mode_q    <= MODE_CHECKER;
            offx_q    <= 8'd0;
            offy_q    <= 8'd0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
            pending_q <= pending_d;
            mode_q    <= mode_d;
            offx_q    <= offx_d;
            offy_q    <= offy_d;
        end
    end

    // Output registers, all derived from the same counter state for alignment.
    always_ff @(posedge PIXEL_CLK or posedge RESET) begin
        if (RESET) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            den_q   <= 1'b0;
            fs_q    <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            x_q     <= 11'd0;
            y_q     <= 11'd0;
        end else begin
            hsync_q <= ~h_sync;
            vsync_q <= ~v_sync;
            den_q   <= h_active & v_active;
            fs_q    <= at_origin;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            x_q     <= h_q;
            y_q     <= v_q;
        end
    end

    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign DEN         = den_q;
    assign FRAME_START = fs_q;
    assign LCD_R       = r_q;
    assign LCD_G       = g_q;
    assign LCD_B       = b_q;
    assign XPOS        = x_q;
    assign YPOS        = y_q;
    assign MODE        = mode_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench for lcd_pattern_gen using a small raster (25 x 12 total, 16 x 8 visible).
module tb_lcd_pattern_gen;

    logic        PIXEL_CLK = 1'b0;
    logic        RESET;
    logic        MODE_NEXT;
    logic        SCROLL_EN;
    logic        HSYNC, VSYNC, DEN, FRAME_START;
    logic [4:0]  LCD_R;
    logic [5:0]  LCD_G;
    logic [4:0]  LCD_B;
    logic [10:0] XPOS, YPOS;
    logic [1:0]  MODE;

    int total = 0;
    int bad   = 0;

    lcd_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .PIXEL_CLK(PIXEL_CLK),
        .RESET(RESET),
        .MODE_NEXT(MODE_NEXT),
        .SCROLL_EN(SCROLL_EN),
        .HSYNC(HSYNC),
        .VSYNC(VSYNC),
        .DEN(DEN),
        .LCD_R(LCD_R),
        .LCD_G(LCD_G),
        .LCD_B(LCD_B),
        .XPOS(XPOS),
        .YPOS(YPOS),
        .MODE(MODE),
        .FRAME_START(FRAME_START)
    );

    always #5 PIXEL_CLK = ~PIXEL_CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge PIXEL_CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_next();
        MODE_NEXT = 1'b1;
        tick();
        MODE_NEXT = 1'b0;
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!FRAME_START && n < 1000);
        check_val(tag, FRAME_START, 1);
    endtask

    task automatic check_rgb(input string tag, input int r, input int g, input int b);
        check_val({tag, "_r"}, LCD_R, r);
        check_val({tag, "_g"}, LCD_G, g);
        check_val({tag, "_b"}, LCD_B, b);
    endtask

    initial begin
        int hs_low, den_cnt, ex, vs_low, fs_at, white_ok, blank_ok;
        RESET     = 1'b1;
        MODE_NEXT = 1'b0;
        SCROLL_EN = 1'b0;
        ticks(3);
        RESET = 1'b0;

        // Reset asserted mid-line: outputs return to reset values without waiting for a clock.
        ticks(37);
        check_val("pre_rst_x", XPOS, 11);
        check_val("pre_rst_y", YPOS, 1);
        check_val("pre_rst_den", DEN, 1);
        RESET = 1'b1;
        #1;
        check_val("rst_hsync", HSYNC, 1);
        check_val("rst_vsync", VSYNC, 1);
        check_val("rst_den", DEN, 0);
        check_val("rst_rgb", {LCD_R, LCD_G, LCD_B}, 0);
        check_val("rst_x", XPOS, 0);
        check_val("rst_y", YPOS, 0);
        check_val("rst_mode", MODE, 0);
        check_val("rst_fs", FRAME_START, 0);
        ticks(2);
        RESET = 1'b0;
        tick();
        check_val("post_rst_fs", FRAME_START, 1);
        check_val("post_rst_den", DEN, 1);

        // Two lines of line timing starting at state (0,0).
        hs_low = 0; den_cnt = 0; ex = 0;
        for (int i = 0; i < 50; i++) begin
            if (!HSYNC) hs_low++;
            if (DEN) begin
                den_cnt++;
                check_val("line_xpos", XPOS, ex);
                ex++;
            end else begin
                ex = 0;
            end
            tick();
        end
        check_val("hsync_low_2lines", hs_low, 6);
        check_val("den_high_2lines", den_cnt, 32);

        // One full frame: vsync width and frame period.
        wait_fs("fs_t3");
        vs_low = 0; fs_at = 0;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (!VSYNC) vs_low++;
            if (FRAME_START && fs_at == 0) fs_at = n;
        end
        check_val("vsync_low_frame", vs_low, 50);
        check_val("fs_period", fs_at, 300);

        // Two requests in one frame advance the mode by one at the next frame start.
        ticks(10);
        pulse_next();
        ticks(20);
        pulse_next();
        check_val("mode_hold_midframe", MODE, 0);
        wait_fs("fs_t4");
        check_val("mode_bars", MODE, 1);
        check_val("bars_x0_pos", XPOS, 0);
        check_rgb("bars_x0", 31, 63, 31);
        ticks(2);
        check_val("bars_x2_pos", XPOS, 2);
        check_rgb("bars_x2", 31, 63, 0);
        ticks(12);
        check_val("bars_x14_pos", XPOS, 14);
        check_rgb("bars_x14", 0, 0, 0);

        // One request per frame: ramp, white, then back to checker.
        pulse_next();
        wait_fs("fs_ramp");
        check_val("mode_ramp", MODE, 2);
        ticks(15);
        check_val("ramp_x15_pos", XPOS, 15);
        check_rgb("ramp_x15", 1, 3, 1);
        pulse_next();
        wait_fs("fs_white");
        check_val("mode_white", MODE, 3);
        white_ok = 0; blank_ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (DEN && LCD_R == 5'h1f && LCD_G == 6'h3f && LCD_B == 5'h1f) white_ok++;
            if (!DEN && LCD_R == 5'h0 && LCD_G == 6'h0 && LCD_B == 5'h0) blank_ok++;
            MODE_NEXT = (i == 10);
            tick();
        end
        MODE_NEXT = 1'b0;
        check_val("white_active_px", white_ok, 128);
        check_val("white_blank_px", blank_ok, 172);
        check_val("fs_after_white", FRAME_START, 1);
        check_val("mode_wrap_0", MODE, 0);

        // Checker scrolling across 86 frame starts: offx 3,6,..,255,2 and offy 2,4,..,172.
        SCROLL_EN = 1'b1;
        for (int f = 1; f <= 86; f++) begin
            wait_fs("fs_scroll");
            if (f == 1)  check_rgb("chk_f1", 0, 0, 0);
            if (f == 85) check_rgb("chk_f85", 0, 63, 0);
            if (f == 86) check_rgb("chk_f86", 31, 0, 31);
        end
        SCROLL_EN = 1'b0;
        ticks(5);
        check_val("chk_f86_x5_pos", XPOS, 5);
        check_rgb("chk_f86_x5", 31, 0, 31);
        wait_fs("fs_scroll_off");
        check_rgb("chk_frozen", 31, 0, 31);

        // Request coincident with counter state (0,0) takes effect in that same frame.
        ticks(299);
        check_val("pre_origin_x", XPOS, 24);
        check_val("pre_origin_y", YPOS, 11);
        MODE_NEXT = 1'b1;
        tick();
        MODE_NEXT = 1'b0;
        check_val("coinc_fs", FRAME_START, 1);
        check_val("coinc_mode", MODE, 1);
        wait_fs("fs_after_coinc");
        check_val("coinc_consumed", MODE, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
